hcsr04_medidor_n: RTL and testbench

- Complete, parametrised HC-SR04 measurement engine: control FSM plus datapath in one block.
- Generates the trigger pulse, waits for echo with a timeout, and measures echo width in centimetres as a D-digit BCD value with round-half-up.
- Registers the result and flags errors. Supports single-shot and continuous modes.
- Sits between the sensor pins and the display/serial logic in the top level.

---
 rtl/hcsr04_medidor_n_if.sv | 24 ++
 rtl/hcsr04_medidor_n.sv | 194 +++++++++++++++++++
 tb/tb_hcsr04_medidor_n.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hcsr04_medidor_n_if.sv
// Sensor-side and result signals of the HC-SR04 measurement engine.
interface hcsr04_medidor_n_if #(
  parameter int DIGITOS = 3
);
  logic                   i_medir;
  logic                   i_continuo;
  logic                   i_echo;
  logic                   o_trigger;
  logic [4*DIGITOS-1:0]   o_distancia;
  logic                   o_pronto;
  logic                   o_ocupado;
  logic [1:0]             o_codigo_erro;
  logic [3:0]             o_db_estado;

  modport slave (
    input  i_medir, i_continuo, i_echo,
    output o_trigger, o_distancia, o_pronto, o_ocupado, o_codigo_erro, o_db_estado
  );

  modport master (
    output i_medir, i_continuo, i_echo,
    input  o_trigger, o_distancia, o_pronto, o_ocupado, o_codigo_erro, o_db_estado
  );
endinterface

// File: rtl/hcsr04_medidor_n.sv
// HC-SR04 measurement engine: trigger generation, echo timing, BCD distance with round-half-up.
// state      | meaning
// INICIAL    | idle, waits for medir
// PREPARA    | clears tick, BCD and timeout counters
// TRIGGER    | drives trigger high for TRIG_CICLOS clocks
// ESPERA_ECO | waits for echo rise, bounded by TIMEOUT_ESPERA
// MEDE       | counts echo-high clocks into tick/BCD, bounded by TIMEOUT_ECO
// ARMAZENA   | rounds, saturates and loads the result
// FINAL      | one-clock pronto, chooses idle or holdoff
// INTERVALO  | continuous-mode holdoff of INTERVALO_CICLOS clocks
module hcsr04_medidor_n #(
  parameter int TRIG_CICLOS      = 500,
  parameter int CICLOS_CM        = 2941,
  parameter int DIGITOS          = 3,
  parameter int TIMEOUT_ESPERA   = 1500000,
  parameter int TIMEOUT_ECO      = 1500000,
  parameter int INTERVALO_CICLOS = 3000000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  hcsr04_medidor_n_if.slave       bus
);

  localparam int MAX_AB = (TRIG_CICLOS > TIMEOUT_ESPERA) ? TRIG_CICLOS : TIMEOUT_ESPERA;
  localparam int MAX_C  = (MAX_AB > INTERVALO_CICLOS) ? MAX_AB : INTERVALO_CICLOS;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int TICK_W = $clog2(CICLOS_CM + 1);
  localparam int ALTO_W = $clog2(TIMEOUT_ECO + 1);
  localparam int BCD_W  = 4 * DIGITOS;
  localparam logic [BCD_W-1:0] NOVES = {DIGITOS{4'd9}};

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    TRIGGER    = 4'd2,
    ESPERA_ECO = 4'd3,
    MEDE       = 4'd4,
    ARMAZENA   = 4'd5,
    FINAL      = 4'd6,
    INTERVALO  = 4'd7
  } estado_t;

  estado_t           r_estado;
  logic              r_echo_m;
  logic              r_echo_s;
  logic [CNT_W-1:0]  r_cnt;
  logic [TICK_W-1:0] r_tick;
  logic [ALTO_W-1:0] r_alto;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_sat;
  logic              r_trigger;
  logic              r_pronto;
  logic [BCD_W-1:0]  r_dist;
  logic [1:0]        r_erro;
  logic [BCD_W:0]    w_inc;

  // Decimal increment; MSB is the carry out of the top digit.
  function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITOS; d++) begin
      if (c) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  assign w_inc = bcd_inc(r_bcd);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_estado  <= INICIAL;
      r_echo_m  <= 1'b0;
      r_echo_s  <= 1'b0;
      r_cnt     <= '0;
      r_tick    <= '0;
      r_alto    <= '0;
      r_bcd     <= '0;
      r_sat     <= 1'b0;
      r_trigger <= 1'b0;
      r_pronto  <= 1'b0;
      r_dist    <= '0;
      r_erro    <= 2'b00;
    end else begin
      r_echo_m <= bus.i_echo;
      r_echo_s <= r_echo_m;
      r_pronto <= 1'b0;
      case (r_estado)
        INICIAL: begin
          if (bus.i_medir) r_estado <= PREPARA;
        end
        PREPARA: begin
          r_cnt    <= '0;
          r_tick   <= '0;
          r_alto   <= '0;
          r_bcd    <= '0;
          r_sat    <= 1'b0;
          r_estado <= TRIGGER;
        end
        TRIGGER: begin
          // First clock here raises trigger, so it is high for exactly TRIG_CICLOS clocks.
          if (r_cnt == CNT_W'(TRIG_CICLOS)) begin
            r_trigger <= 1'b0;
            r_cnt     <= '0;
            r_estado  <= ESPERA_ECO;
          end else begin
            r_trigger <= 1'b1;
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        ESPERA_ECO: begin
          if (r_echo_s) begin
            r_tick   <= TICK_W'(1);
            r_alto   <= ALTO_W'(1);
            r_estado <= MEDE;
          end else if (r_cnt == CNT_W'(TIMEOUT_ESPERA - 1)) begin
            r_erro   <= 2'b01;
            r_pronto <= 1'b1;
            r_estado <= FINAL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MEDE: begin
          if (!r_echo_s) begin
            r_estado <= ARMAZENA;
          end else if (r_alto == ALTO_W'(TIMEOUT_ECO - 1)) begin
            r_erro   <= 2'b10;
            r_pronto <= 1'b1;
            r_estado <= FINAL;
          end else begin
            r_alto <= r_alto + 1'b1;
            if (r_tick == TICK_W'(CICLOS_CM - 1)) begin
              r_tick <= '0;
              if (w_inc[BCD_W]) r_sat <= 1'b1;
              else              r_bcd <= w_inc[BCD_W-1:0];
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        ARMAZENA: begin
          r_pronto <= 1'b1;
          r_estado <= FINAL;
          if (r_sat) begin
            r_dist <= NOVES;
            r_erro <= 2'b11;
          end else if (r_tick >= TICK_W'(CICLOS_CM / 2)) begin
            if (w_inc[BCD_W]) begin
              r_dist <= NOVES;
              r_erro <= 2'b11;
            end else begin
              r_dist <= w_inc[BCD_W-1:0];
              r_erro <= 2'b00;
            end
          end else begin
            r_dist <= r_bcd;
            r_erro <= 2'b00;
          end
        end
        FINAL: begin
          if (bus.i_continuo) begin
            r_cnt    <= '0;
            r_estado <= INTERVALO;
          end else begin
            r_estado <= INICIAL;
          end
        end
        INTERVALO: begin
          if (!bus.i_continuo)                               r_estado <= INICIAL;
          else if (r_cnt == CNT_W'(INTERVALO_CICLOS - 1))   r_estado <= PREPARA;
          else                                               r_cnt    <= r_cnt + 1'b1;
        end
        default: r_estado <= INICIAL;
      endcase
    end
  end

  assign bus.o_trigger     = r_trigger;
  assign bus.o_distancia   = r_dist;
  assign bus.o_pronto      = r_pronto;
  assign bus.o_ocupado     = (r_estado != INICIAL);
  assign bus.o_codigo_erro = r_erro;
  assign bus.o_db_estado   = r_estado;

endmodule

// File: tb/tb_hcsr04_medidor_n.sv
// Bench for hcsr04_medidor_n: vector table, randomized widths against an arithmetic model, corner sequences.
module tb_hcsr04_medidor_n;
  localparam int TRIG = 5;
  localparam int CCM  = 10;
  localparam int DIG  = 2;
  localparam int TOE  = 40;
  localparam int TOM  = 1200;
  localparam int INTV = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tot = 0;
  int   n_pass = 0;

  hcsr04_medidor_n_if #(.DIGITOS(DIG)) bus ();

  hcsr04_medidor_n #(
    .TRIG_CICLOS(TRIG), .CICLOS_CM(CCM), .DIGITOS(DIG),
    .TIMEOUT_ESPERA(TOE), .TIMEOUT_ECO(TOM), .INTERVALO_CICLOS(INTV)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         w;
    logic [7:0] d;
    logic [1:0] e;
  } vec_t;

  vec_t tab[14];

  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Reference: round-half-up of W/CCM, clamped to 99; W=0 means no echo at all.
  function automatic void model(input int w, inout logic [7:0] d, output logic [1:0] e);
    int r;
    if (w == 0) e = 2'd1;
    else if (w >= TOM) e = 2'd2;
    else begin
      r = w / CCM + (((w % CCM) >= CCM / 2) ? 1 : 0);
      if (r > 99) begin r = 99; e = 2'd3; end
      else e = 2'd0;
      d = 8'((r / 10) * 16 + (r % 10));
    end
  endfunction

  task automatic run(input int w, input int dly, output int trig_n, output int pr_n,
                     output logic [7:0] d, output logic [1:0] e);
    trig_n = 0; pr_n = 0; d = '0; e = '0;
    @(negedge clk) bus.i_medir = 1'b1;
    @(negedge clk) bus.i_medir = 1'b0;
    fork
      begin
        int t;
        t = 0;
        while (!bus.o_trigger && t < 50) begin @(negedge clk); t++; end
        while (bus.o_trigger && t < 100) begin @(negedge clk); t++; end
        repeat (dly) @(negedge clk);
        if (w > 0) begin
          bus.i_echo = 1'b1;
          repeat (w) @(negedge clk);
          bus.i_echo = 1'b0;
        end
      end
      begin
        for (int c = 0; c < w + dly + 120; c++) begin
          @(negedge clk);
          if (bus.o_trigger) trig_n++;
          if (bus.o_pronto) begin
            pr_n++;
            d = bus.o_distancia;
            e = bus.o_codigo_erro;
          end
        end
      end
    join
  endtask

  task automatic do_meas(input string nm, input int w, input int dly,
                         input logic [7:0] ed, input logic [1:0] ee);
    int tn, pn;
    logic [7:0] d;
    logic [1:0] e;
    run(w, dly, tn, pn, d, e);
    check({nm, "_trig_width"}, tn, TRIG);
    check({nm, "_pronto_count"}, pn, 1);
    check({nm, "_distancia"}, int'(d), int'(ed));
    check({nm, "_codigo_erro"}, int'(e), int'(ee));
    check({nm, "_ocupado_after"}, int'(bus.o_ocupado), 0);
  endtask

  initial begin
    logic [7:0] mdl_d;
    logic [1:0] mdl_e;
    int w, dly, t;

    tab[0]  = '{54,   8'h05, 2'd0};
    tab[1]  = '{9,    8'h01, 2'd0};
    tab[2]  = '{4,    8'h00, 2'd0};
    tab[3]  = '{5,    8'h01, 2'd0};
    tab[4]  = '{95,   8'h10, 2'd0};
    tab[5]  = '{57,   8'h06, 2'd0};
    tab[6]  = '{0,    8'h06, 2'd1};
    tab[7]  = '{1000, 8'h99, 2'd3};
    tab[8]  = '{1300, 8'h99, 2'd2};
    tab[9]  = '{57,   8'h06, 2'd0};
    tab[10] = '{985,  8'h99, 2'd0};
    tab[11] = '{995,  8'h99, 2'd3};
    tab[12] = '{1199, 8'h99, 2'd3};
    tab[13] = '{1200, 8'h99, 2'd2};

    bus.i_medir = 1'b0;
    bus.i_continuo = 1'b0;
    bus.i_echo = 1'b0;

    #12;
    check("rst_trigger", int'(bus.o_trigger), 0);
    check("rst_pronto", int'(bus.o_pronto), 0);
    check("rst_ocupado", int'(bus.o_ocupado), 0);
    check("rst_distancia", int'(bus.o_distancia), 0);
    check("rst_codigo_erro", int'(bus.o_codigo_erro), 0);
    check("rst_estado", int'(bus.o_db_estado), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency from medir sample to trigger, then reset while trigger is high.
    bus.i_medir = 1'b1;
    @(negedge clk) bus.i_medir = 1'b0;
    check("lat_estado_prepara", int'(bus.o_db_estado), 1);
    check("lat_trig_low0", int'(bus.o_trigger), 0);
    @(negedge clk);
    check("lat_estado_trigger", int'(bus.o_db_estado), 2);
    check("lat_trig_low1", int'(bus.o_trigger), 0);
    @(negedge clk);
    check("lat_trig_high", int'(bus.o_trigger), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_trig_async", int'(bus.o_trigger), 0);
    check("rst_trig_estado", int'(bus.o_db_estado), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tab[i]) begin
      do_meas($sformatf("vec%0d_w%0d", i, tab[i].w), tab[i].w, 3, tab[i].d, tab[i].e);
    end

    mdl_d = tab[13].d;
    for (int k = 0; k < 12; k++) begin
      w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1250));
      dly = int'($urandom_range(0, 20));
      model(w, mdl_d, mdl_e);
      do_meas($sformatf("rnd%0d_w%0d", k, w), w, dly, mdl_d, mdl_e);
    end

    // Continuous mode: three measurements of W=123 with the holdoff measured in between.
    bus.i_continuo = 1'b1;
    @(negedge clk) bus.i_medir = 1'b1;
    @(negedge clk) bus.i_medir = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          int tw;
          tw = 0;
          while (!bus.o_trigger && tw < 300) begin @(negedge clk); tw++; end
          while (bus.o_trigger && tw < 300) begin @(negedge clk); tw++; end
          repeat (3) @(negedge clk);
          bus.i_echo = 1'b1;
          repeat (123) @(negedge clk);
          bus.i_echo = 1'b0;
        end
      end
      begin
        int   pr, iv;
        logic in_iv;
        pr = 0; iv = 0; in_iv = 1'b0;
        for (int c = 0; c < 1000 && pr < 3; c++) begin
          @(negedge clk);
          if (bus.o_db_estado == 4'd6) begin
            in_iv = 1'b1;
            iv = 0;
          end else if (bus.o_db_estado == 4'd7 && in_iv) begin
            iv++;
          end else if (bus.o_db_estado == 4'd1 && in_iv) begin
            check("cont_interval_clocks", iv, INTV);
            in_iv = 1'b0;
          end
          if (bus.o_pronto) begin
            pr++;
            check("cont_distancia", int'(bus.o_distancia), 8'h12);
            check("cont_codigo_erro", int'(bus.o_codigo_erro), 0);
          end
        end
        check("cont_pronto_count", pr, 3);
      end
    join
    @(negedge clk);
    check("cont_enter_intervalo", int'(bus.o_db_estado), 7);
    bus.i_continuo = 1'b0;
    @(negedge clk);
    check("cont_drop_inicial", int'(bus.o_db_estado), 0);
    check("cont_drop_ocupado", int'(bus.o_ocupado), 0);
    repeat (3) @(negedge clk);

    // Reset in the middle of MEDE.
    bus.i_medir = 1'b1;
    @(negedge clk) bus.i_medir = 1'b0;
    t = 0;
    while (!bus.o_trigger && t < 50) begin @(negedge clk); t++; end
    while (bus.o_trigger && t < 100) begin @(negedge clk); t++; end
    bus.i_echo = 1'b1;
    while (bus.o_db_estado != 4'd4 && t < 150) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    check("mede_reached", int'(bus.o_db_estado), 4);
    #2 rst_n = 1'b0;
    #1;
    check("mede_rst_trigger", int'(bus.o_trigger), 0);
    check("mede_rst_distancia", int'(bus.o_distancia), 0);
    check("mede_rst_estado", int'(bus.o_db_estado), 0);
    check("mede_rst_erro", int'(bus.o_codigo_erro), 0);
    bus.i_echo = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mede_post_distancia", int'(bus.o_distancia), 0);
    check("mede_post_estado", int'(bus.o_db_estado), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
